// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding a UART serializer: buffers host writes and
// launches one byte at a time, paced by the UART is_transmitting flag.
module uart_tx_fifo #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_stb,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  input  logic                  is_transmitting,
  output logic                  byte_sent,
  output logic                  tx_lost,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned TW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  logic [7:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q;
  logic                  transmit_q;
  logic [7:0]            tx_byte_q;
  logic                  byte_sent_q;
  logic                  tx_lost_q;
  logic [TW-1:0]         timer_q;
  state_e                state_q;
  logic                  wr_en;
  logic                  pop;

  // Status flags decode the registered occupancy, so a same-cycle pop never frees a slot.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign busy  = (state_q != IDLE);

  assign wr_en = wr_stb && !full && !flush;
  assign pop   = (state_q == IDLE) && !empty && !is_transmitting && !flush;

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign transmit  = transmit_q;
  assign tx_byte   = tx_byte_q;
  assign byte_sent = byte_sent_q;
  assign tx_lost   = tx_lost_q;

  // Pointer and occupancy next-state; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= wr_stb && full && !flush;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // Launch / handshake FSM; strobes default low so each is a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      transmit_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
      byte_sent_q <= 1'b0;
      tx_lost_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      transmit_q  <= 1'b0;
      byte_sent_q <= 1'b0;
      tx_lost_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_byte_q  <= mem_q[rd_ptr_q];
            transmit_q <= 1'b1;
            timer_q    <= '0;
            state_q    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          timer_q <= timer_q + TW'(1);
          if (is_transmitting) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
            tx_lost_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!is_transmitting) begin
            byte_sent_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed vector table, corner-case
// sequences, then randomized traffic against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned BTO   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_stb;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          transmit;
  logic [7:0]    tx_byte;
  logic          is_transmitting;
  logic          byte_sent;
  logic          tx_lost;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_fifo #(.ADDR_WIDTH(AW), .BUSY_TIMEOUT(BTO)) dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting),
    .byte_sent(byte_sent), .tx_lost(tx_lost), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       fl;
    logic       it;
    int         cnt;
    logic       emp;
    logic       tr;
    logic [7:0] txb;
    logic       sent;
    logic       lost;
    logic       bsy;
    logic       ovf;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic it,
                              input int cnt, input logic emp, input logic tr,
                              input logic [7:0] txb, input logic sent, input logic lost,
                              input logic bsy);
    vec_t v;
    v.wr = wr; v.wd = wd; v.fl = 1'b0; v.it = it;
    v.cnt = cnt; v.emp = emp; v.tr = tr; v.txb = txb;
    v.sent = sent; v.lost = lost; v.bsy = bsy; v.ovf = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic f, input logic it);
    wr_stb = w; wr_data = d; flush = f; is_transmitting = it;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_transmit"}, 32'(transmit), 0);
    chk({tag, "_tx_byte"}, 32'(tx_byte), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_byte_sent"}, 32'(byte_sent), 0);
    chk({tag, "_tx_lost"}, 32'(tx_lost), 0);
  endtask

  // Reference model: byte queue plus a launch phase (0 none, 1 awaiting busy, 2 on the wire).
  logic [7:0] mq[$];
  int         m_phase;
  int         m_age;
  logic [7:0] m_txb;

  task automatic rstep(input logic w, input logic [7:0] d, input logic f, input logic it);
    bit was_full, was_empty, e_ov, e_tr, e_sent, e_lost;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    e_ov = w && was_full && !f;
    e_tr = 0; e_sent = 0; e_lost = 0;
    if (m_phase == 0) begin
      if (!was_empty && !it && !f) begin
        m_txb = mq.pop_front();
        e_tr = 1; m_age = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (it) m_phase = 2;
      else if (m_age == BTO - 1) begin e_lost = 1; m_phase = 0; end
      m_age++;
    end else begin
      if (!it) begin e_sent = 1; m_phase = 0; end
    end
    if (f) mq.delete();
    else if (w && !was_full) mq.push_back(d);
    cyc(w, d, f, it);
    chk("rnd_count", 32'(count), 32'(mq.size()));
    chk("rnd_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
    chk("rnd_overflow", 32'(overflow), 32'(e_ov));
    chk("rnd_transmit", 32'(transmit), 32'(e_tr));
    chk("rnd_tx_byte", 32'(tx_byte), 32'(m_txb));
    chk("rnd_byte_sent", 32'(byte_sent), 32'(e_sent));
    chk("rnd_tx_lost", 32'(tx_lost), 32'(e_lost));
    chk("rnd_busy", 32'(busy), 32'(m_phase != 0));
  endtask

  initial begin
    int got;
    int busy_cnt;
    logic it_v;
    logic [7:0] exp_b;

    rst = 1'b1; wr_stb = 0; wr_data = 0; flush = 0; is_transmitting = 0;

    // Single byte then timeout case, cycle by cycle.
    vt[0]  = mk(1, 8'h55, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    vt[1]  = mk(0, 8'h00, 0, 0, 1, 1, 8'h55, 0, 0, 1);
    vt[2]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h55, 0, 0, 1);
    vt[3]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h55, 0, 0, 1);
    vt[4]  = mk(0, 8'h00, 0, 0, 1, 0, 8'h55, 1, 0, 0);
    vt[5]  = mk(0, 8'h00, 0, 0, 1, 0, 8'h55, 0, 0, 0);
    vt[6]  = mk(1, 8'hA1, 0, 1, 0, 0, 8'h55, 0, 0, 0);
    vt[7]  = mk(1, 8'hB2, 0, 1, 0, 1, 8'hA1, 0, 0, 1);
    vt[8]  = mk(0, 8'h00, 0, 1, 0, 0, 8'hA1, 0, 0, 1);
    vt[9]  = mk(0, 8'h00, 0, 1, 0, 0, 8'hA1, 0, 0, 1);
    vt[10] = mk(0, 8'h00, 0, 1, 0, 0, 8'hA1, 0, 0, 1);
    vt[11] = mk(0, 8'h00, 0, 1, 0, 0, 8'hA1, 0, 1, 0);
    vt[12] = mk(0, 8'h00, 0, 0, 1, 1, 8'hB2, 0, 0, 1);
    vt[13] = mk(0, 8'h00, 1, 0, 1, 0, 8'hB2, 0, 0, 1);
    vt[14] = mk(0, 8'h00, 0, 0, 1, 0, 8'hB2, 1, 0, 0);
    vt[15] = mk(0, 8'h00, 0, 0, 1, 0, 8'hB2, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cyc(vt[i].wr, vt[i].wd, vt[i].fl, vt[i].it);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].emp));
      chk($sformatf("vec%0d_transmit", i), 32'(transmit), 32'(vt[i].tr));
      chk($sformatf("vec%0d_tx_byte", i), 32'(tx_byte), 32'(vt[i].txb));
      chk($sformatf("vec%0d_byte_sent", i), 32'(byte_sent), 32'(vt[i].sent));
      chk($sformatf("vec%0d_tx_lost", i), 32'(tx_lost), 32'(vt[i].lost));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].ovf));
    end

    // Fill to full while UART busy, then overflow.
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 1);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_overflow_quiet", 32'(overflow), 0);
    cyc(1, 8'hAA, 0, 1);
    chk("ovf17_overflow", 32'(overflow), 1);
    chk("ovf17_count", 32'(count), 16);
    cyc(0, 8'h00, 0, 1);
    chk("ovf17_strobe_end", 32'(overflow), 0);

    // Write while full coincides with launch pop: dropped.
    cyc(1, 8'hBB, 0, 0);
    chk("popwr_overflow", 32'(overflow), 1);
    chk("popwr_count", 32'(count), 15);
    chk("popwr_transmit", 32'(transmit), 1);
    chk("popwr_tx_byte", 32'(tx_byte), 8'h00);

    // Drain with a responsive UART and check ordering.
    got = 0; busy_cnt = 2; it_v = 1; exp_b = 8'h01;
    for (int k = 0; k < 600 && got < 15; k++) begin
      cyc(0, 8'h00, 0, it_v);
      if (transmit) begin
        chk($sformatf("drain_order%0d", got), 32'(tx_byte), 32'(exp_b));
        exp_b++; got++; busy_cnt = 3;
      end
      it_v = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
    chk("drain_bytes", 32'(got), 15);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 8'h00, 0, it_v);
      it_v = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_idle", 32'(busy), 0);

    // Flush while first byte is in flight.
    cyc(1, 8'hC0, 0, 0);
    chk("fl_count1", 32'(count), 1);
    cyc(1, 8'hC1, 0, 0);
    chk("fl_launch", 32'(transmit), 1);
    chk("fl_launch_byte", 32'(tx_byte), 8'hC0);
    cyc(1, 8'hC2, 0, 1);
    cyc(1, 8'hC3, 0, 1);
    cyc(1, 8'hC4, 0, 1);
    chk("fl_count4", 32'(count), 4);
    cyc(0, 8'h00, 1, 1);
    chk("fl_count0", 32'(count), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_still_busy", 32'(busy), 1);
    cyc(0, 8'h00, 0, 1);
    chk("fl_inflight", 32'(busy), 1);
    cyc(0, 8'h00, 0, 0);
    chk("fl_byte_sent", 32'(byte_sent), 1);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 8'h00, 0, 0);
      chk($sformatf("fl_no_tx%0d", k), 32'(transmit), 0);
    end

    // Async reset during WAIT_DONE with a byte still queued.
    cyc(1, 8'hD0, 0, 0);
    cyc(1, 8'hD1, 0, 0);
    chk("rs_launch", 32'(transmit), 1);
    cyc(0, 8'h00, 0, 1);
    chk("rs_wait_done", 32'(busy), 1);
    chk("rs_count1", 32'(count), 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 8'h00, 0, (k < 2));
      chk($sformatf("rs_no_tx%0d", k), 32'(transmit), 0);
      chk($sformatf("rs_empty%0d", k), 32'(empty), 1);
    end

    // Randomized traffic against the reference model.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    mq.delete(); m_phase = 0; m_age = 0; m_txb = 8'h00;
    it_v = 0;
    for (int c = 0; c < 3000; c++) begin
      logic w, f;
      if (((c / 150) % 2) == 0) w = ($urandom_range(0, 3) != 0);
      else                      w = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) it_v = ~it_v;
      rstep(w, 8'($urandom), f, it_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
